adder_batch_issuer64: RTL and testbench

//  Initiator side of the 64-bit add/sub unit handshake (sta/add_sub/x/y -> done_sig/xy). On start it streams
//  a batch of operand pairs from an operand RAM into the adder at one per clock, and writes each result
//  in order to a result RAM. It pulses done when the last result is written. Sits between the solver

---
 rtl/adder_batch_issuer64_pkg.sv | 18 +
 rtl/adder_batch_issuer64_delay_1clk.sv | 17 +
 rtl/adder_batch_issuer64.sv | 148 ++++++++++++++
 tb/tb_adder_batch_issuer64.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_batch_issuer64_pkg.sv
// Shared widths, adder timing constant and sequencer state encoding for the batch issuer.
package adder_batch_issuer64_pkg;

  // Extended-single operand/result width.
  localparam int EXTENDED_SINGLE = 64;
  // Operand/result RAM address width; a batch holds up to 2**ADDR_W pairs.
  localparam int ADDR_W = 8;
  // Adder latency from add_sta to add_done. Nothing in the issuer is sized by it.
  localparam int ADDER_LATENCY = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_batch_issuer64_delay_1clk.sv
// One-cycle register stage; aligns the operand read strobe with the RAM's one-cycle read data.
module adder_batch_issuer64_delay_1clk #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // register d by one clock, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/adder_batch_issuer64.sv
// Batch issuer: streams operand pairs from the operand RAM into the 64-bit add/sub unit,
// one per clock, and writes the in-order results back to the result RAM.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for start; op_cnt/op_sub latched when start is taken
//   ST_ISSUE | one operand RAM read per cycle, addresses 0..cnt-1
//   ST_DRAIN | reads finished; waiting for all results to come back
//   ST_DONE  | single cycle with done=1, then back to ST_IDLE
module adder_batch_issuer64
  import adder_batch_issuer64_pkg::*;
#(
  parameter int DW = EXTENDED_SINGLE,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   op_cnt,
  input  logic          op_sub,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_x,
  input  logic [DW-1:0] rd_y,
  output logic          add_sta,
  output logic          add_add_sub,
  output logic [DW-1:0] add_x,
  output logic [DW-1:0] add_y,
  input  logic          add_done,
  input  logic [DW-1:0] add_xy,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t      state;
  logic [AW:0] cnt;
  logic [AW:0] last_idx;
  logic [AW:0] wb_cnt;
  logic [AW:0] outstanding;
  logic        sub_q;
  logic        start_acc;
  logic        done_ok;

  assign start_acc = (state == ST_IDLE) && start;
  assign last_idx  = cnt - {{AW{1'b0}}, 1'b1};
  // A result strobe only counts when something is actually in flight.
  assign done_ok   = add_done && (outstanding != '0);

  // batch sequencer: accepts start, walks read addresses, waits for drain, pulses done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sub_q   <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= op_cnt;
            sub_q <= op_sub;
            busy  <= 1'b1;
            if (op_cnt == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_ISSUE;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if ({1'b0, rd_addr} == last_idx) begin
            // Returning to 0 also covers the wrap of a full 2**AW batch.
            state   <= ST_DRAIN;
            rd_en   <= 1'b0;
            rd_addr <= '0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if ((wb_cnt == cnt) && (outstanding == '0)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          rd_en <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  adder_batch_issuer64_delay_1clk #(.W(1)) u_sta_dly (
    .clk (clk),
    .rst (rst),
    .d   (rd_en),
    .q   (add_sta)
  );

  // Read data lands in the same cycle as add_sta; operands are zero when nothing is issued.
  assign add_x       = add_sta ? rd_x : '0;
  assign add_y       = add_sta ? rd_y : '0;
  assign add_add_sub = sub_q;

  // writeback, in-flight tracking and the sticky unexpected-result flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wb_cnt      <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start_acc) wb_cnt <= '0;
      if (done_ok) begin
        wr_en   <= 1'b1;
        wr_data <= add_xy;
        wr_addr <= wb_cnt[AW-1:0];
        wb_cnt  <= wb_cnt + 1'b1;
      end else if (add_done) begin
        err <= 1'b1;
      end
      if (add_sta && !done_ok)      outstanding <= outstanding + 1'b1;
      else if (!add_sta && done_ok) outstanding <= outstanding - 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_batch_issuer64.sv
// Bench for adder_batch_issuer64: operand RAM and fixed-latency adder modelled around the DUT,
// batches checked against per-pair expectations derived from operand index and batch length.
module tb_adder_batch_issuer64;
  import adder_batch_issuer64_pkg::*;

  localparam int DW  = 64;
  localparam int AW  = 8;
  localparam int LAT = ADDER_LATENCY;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   op_cnt = '0;
  logic          op_sub = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_x = '0;
  logic [DW-1:0] rd_y = '0;
  logic          add_sta;
  logic          add_add_sub;
  logic [DW-1:0] add_x;
  logic [DW-1:0] add_y;
  logic          add_done = 1'b0;
  logic [DW-1:0] add_xy = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;

  adder_batch_issuer64 #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op_cnt(op_cnt), .op_sub(op_sub),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y),
    .add_sta(add_sta), .add_add_sub(add_add_sub), .add_x(add_x), .add_y(add_y),
    .add_done(add_done), .add_xy(add_xy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int spur_req = 0;
  int spur_ack = 0;

  logic [DW-1:0] mem_x [256];
  logic [DW-1:0] mem_y [256];

  logic          s_rd_en = 1'b0;
  logic          s_sta = 1'b0;
  logic          s_sub = 1'b0;
  logic [AW-1:0] s_rd_addr = '0;
  logic [DW-1:0] s_x = '0;
  logic [DW-1:0] s_y = '0;

  int            rd_cyc_q[$];
  int            rd_addr_q[$];
  int            sta_q[$];
  int            wr_cyc_q[$];
  int            wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            done_q[$];
  int            busy_q[$];

  int            pipe_due[$];
  logic [DW-1:0] pipe_val[$];

  function automatic logic [DW-1:0] fadd(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic sub);
    real r;
    r = sub ? ($bitstoreal(a) - $bitstoreal(b)) : ($bitstoreal(a) + $bitstoreal(b));
    return $realtobits(r);
  endfunction

  // monitor: sample DUT outputs mid-cycle and log every strobe with its cycle number
  always @(negedge clk) begin
    s_rd_en   = rd_en;
    s_rd_addr = rd_addr;
    s_sta     = add_sta;
    s_sub     = add_add_sub;
    s_x       = add_x;
    s_y       = add_y;
    if (rd_en) begin
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(int'(rd_addr));
    end
    if (add_sta) sta_q.push_back(cyc);
    if (wr_en) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(int'(wr_addr));
      wr_data_q.push_back(wr_data);
    end
    if (done) done_q.push_back(cyc);
    if (busy) busy_q.push_back(cyc);
  end

  // environment: registered operand RAM and a fixed-latency in-order adder
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    add_done = 1'b0;
    if (!rst) begin
      pipe_due.delete();
      pipe_val.delete();
      rd_x   = '0;
      rd_y   = '0;
      add_xy = '0;
    end else begin
      if (s_rd_en) begin
        rd_x = mem_x[s_rd_addr];
        rd_y = mem_y[s_rd_addr];
      end
      if (s_sta) begin
        pipe_due.push_back(cyc - 1 + LAT);
        pipe_val.push_back(fadd(s_x, s_y, s_sub));
      end
      if (pipe_due.size() > 0 && pipe_due[0] == cyc) begin
        add_done = 1'b1;
        add_xy   = pipe_val.pop_front();
        void'(pipe_due.pop_front());
      end else if (spur_req != spur_ack) begin
        add_done = 1'b1;
        add_xy   = 64'h0BAD_0BAD_0BAD_0BAD;
        spur_ack = spur_req;
      end
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic outs_any();
    return |{rd_en, rd_addr, add_sta, add_add_sub, add_x, add_y,
             wr_en, wr_addr, wr_data, busy, done, err};
  endfunction

  task automatic fill(input bit rnd);
    for (int i = 0; i < 256; i++) begin
      if (rnd) begin
        mem_x[i] = $realtobits(real'($urandom_range(0, 4000)) / 8.0);
        mem_y[i] = $realtobits(real'($urandom_range(0, 4000)) / 8.0);
      end else begin
        mem_x[i] = $realtobits(real'(i + 1));
        mem_y[i] = $realtobits(0.5);
      end
    end
  endtask

  // one batch: start in cycle t0, expected reads at t0+1+i, issue at t0+2+i,
  // writes at t0+LAT+3+i, done at t0+exp_done, busy over t0+1..t0+exp_done
  task automatic run_batch(input int n, input bit sub, input int exp_done, input bit restart,
                           input logic exp_err, input string tag);
    int t0, rb, sb, wb, db, bb, k;
    tick();
    rb = rd_cyc_q.size();
    sb = sta_q.size();
    wb = wr_cyc_q.size();
    db = done_q.size();
    bb = busy_q.size();
    t0 = cyc;
    op_cnt = (AW+1)'(n);
    op_sub = sub;
    start  = 1'b1;
    for (int r = 1; r <= exp_done + 3; r++) begin
      tick();
      start  = restart && (r == 3 || r == 9 || r == exp_done);
      op_cnt = (AW+1)'($urandom_range(0, 511));
      op_sub = ~sub;
    end
    start = 1'b0;
    tick();

    check_int({tag, " rd count"}, rd_cyc_q.size() - rb, n);
    k = (rd_cyc_q.size() - rb < n) ? rd_cyc_q.size() - rb : n;
    for (int i = 0; i < k; i++) begin
      check_int({tag, " rd cycle"}, rd_cyc_q[rb + i] - t0, 1 + i);
      check_int({tag, " rd addr"}, rd_addr_q[rb + i], i % 256);
    end
    check_int({tag, " sta count"}, sta_q.size() - sb, n);
    if (sta_q.size() > sb) check_int({tag, " first sta cycle"}, sta_q[sb] - t0, 2);
    check_int({tag, " wr count"}, wr_cyc_q.size() - wb, n);
    k = (wr_cyc_q.size() - wb < n) ? wr_cyc_q.size() - wb : n;
    for (int i = 0; i < k; i++) begin
      check_int({tag, " wr cycle"}, wr_cyc_q[wb + i] - t0, LAT + 3 + i);
      check_int({tag, " wr addr"}, wr_addr_q[wb + i], i % 256);
      check_vec({tag, " wr data"}, wr_data_q[wb + i], fadd(mem_x[i], mem_y[i], sub));
    end
    check_int({tag, " done count"}, done_q.size() - db, 1);
    if (done_q.size() > db) check_int({tag, " done cycle"}, done_q[db] - t0, exp_done);
    check_int({tag, " busy cycles"}, busy_q.size() - bb, exp_done);
    if (busy_q.size() > bb) check_int({tag, " busy first"}, busy_q[bb] - t0, 1);
    check_vec({tag, " err"}, 64'(err), 64'(exp_err));
  endtask

  typedef struct {
    int    n;
    bit    sub;
    bit    rnd;
    int    exp_done;
    string tag;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int t0, db, wb, n;

    tbl.push_back('{n: 4,   sub: 1'b0, rnd: 1'b0, exp_done: 14,  tag: "n4-add"});
    tbl.push_back('{n: 0,   sub: 1'b0, rnd: 1'b0, exp_done: 1,   tag: "n0"});
    tbl.push_back('{n: 1,   sub: 1'b1, rnd: 1'b1, exp_done: 11,  tag: "n1-sub"});
    tbl.push_back('{n: 5,   sub: 1'b1, rnd: 1'b1, exp_done: 15,  tag: "n5-sub"});
    tbl.push_back('{n: 256, sub: 1'b1, rnd: 1'b1, exp_done: 266, tag: "n256-sub"});
    tbl.push_back('{n: 13,  sub: 1'b0, rnd: 1'b1, exp_done: 23,  tag: "n13-add"});
    for (int i = 0; i < 3; i++) begin
      n = $urandom_range(1, 40);
      tbl.push_back('{n: n, sub: 1'($urandom_range(0, 1)), rnd: 1'b1,
                      exp_done: n + LAT + 3, tag: "rand"});
    end

    repeat (3) @(posedge clk);
    #2;
    check_vec("reset outputs zero", 64'(outs_any()), 64'd0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      fill(tbl[i].rnd);
      run_batch(tbl[i].n, tbl[i].sub, tbl[i].exp_done, 1'b0, 1'b0, tbl[i].tag);
    end

    // start re-pulsed mid-batch and in the DONE cycle must not disturb the batch
    fill(1'b0);
    run_batch(4, 1'b0, 14, 1'b1, 1'b0, "restart-ignored");

    // reset in the middle of an 8-pair batch
    fill(1'b1);
    tick();
    db = done_q.size();
    wb = wr_cyc_q.size();
    t0 = cyc;
    op_cnt = 9'd8;
    op_sub = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    while (cyc - t0 < 6) tick();
    check_int("pre-reset busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    check_vec("mid-batch reset outputs", 64'(outs_any()), 64'd0);
    @(posedge clk);
    #1;
    check_vec("reset outputs next edge", 64'(outs_any()), 64'd0);
    tick();
    rst = 1'b1;
    repeat (20) tick();
    check_int("reset no done", done_q.size() - db, 0);
    check_int("reset no writes", wr_cyc_q.size() - wb, 0);
    run_batch(8, 1'b1, 18, 1'b0, 1'b0, "post-reset");

    // result strobe with nothing in flight
    tick();
    wb = wr_cyc_q.size();
    spur_req = spur_req + 1;
    repeat (4) tick();
    check_vec("spurious err", 64'(err), 64'd1);
    check_int("spurious no write", wr_cyc_q.size() - wb, 0);
    fill(1'b1);
    run_batch(3, 1'b0, 13, 1'b0, 1'b1, "after-spurious");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
